simon_round_ctrl: RTL

Round sequencer for the memory-game datapath. It plays the current sequence prefix note by note through the tone player, then listens for the player's button presses and checks each one against the stored sequence. It signals `wrong` on the first mismatch and grows the round on success. It sits between the sequence ROM and button debouncer on one side and the music/tone output on the other.

---
 rtl/simon_round_ctrl.sv | 201 ++++++++++++++++++++
 1 files changed

// File: rtl/simon_round_ctrl.sv
// simon_round_ctrl: plays the growing note sequence, then checks the player's presses.
// Optional LISTEN timeout is compiled in when SIMON_TIMEOUT_EN is defined.
module simon_round_ctrl #(
    parameter int TICK_DIV      = 5000000,
    parameter int NOTE_TICKS    = 5,
    parameter int GAP_TICKS     = 2,
    parameter int MAX_LEN       = 16,
    parameter int NOTE_W        = 2,
    parameter int TIMEOUT_TICKS = 30,
    localparam int IW           = $clog2(MAX_LEN)
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic              btn_valid,
    input  logic [NOTE_W-1:0] btn_note,
    input  logic [NOTE_W-1:0] seq_note,
    output logic [IW-1:0]     seq_index,
    output logic [IW:0]       round_len,
    output logic              play_en,
    output logic [NOTE_W-1:0] play_note,
    output logic              is_music_playing,
    output logic              awaiting_input,
    output logic              wrong,
    output logic              round_done,
    output logic              game_won
);

    localparam int DW    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int TMAX0 = (NOTE_TICKS > GAP_TICKS) ? NOTE_TICKS : GAP_TICKS;
    localparam int TMAX  = (TMAX0 > TIMEOUT_TICKS) ? TMAX0 : TIMEOUT_TICKS;
    localparam int TW    = $clog2(TMAX + 1);

    typedef enum logic [2:0] {
        IDLE,
        PLAY_NOTE,
        PLAY_GAP,
        LISTEN,
        FAIL,
        WIN
    } state_t;

    state_t            state;
    state_t            state_n;
    logic [DW-1:0]     div;
    logic [DW-1:0]     div_n;
    logic [TW-1:0]     tcnt;
    logic [TW-1:0]     tcnt_n;
    logic [IW-1:0]     idx_n;
    logic [IW:0]       len_n;
    logic [NOTE_W-1:0] note_n;
    logic [NOTE_W-1:0] first_note;
    logic [NOTE_W-1:0] note0;
    logic              gap_last;
    logic              gap_last_n;
    logic              wrong_n;
    logic              done_n;
    logic              restart;
    logic              tick;
    logic              last;
    logic              match;

    assign tick  = (div == DW'(TICK_DIV - 1));
    assign last  = ({1'b0, seq_index} == round_len - 1'b1);
    assign match = (btn_note == seq_note);
    // The ROM only shows the current address, so note 0 is remembered for
    // restarts that begin while the address still points elsewhere.
    assign note0 = (seq_index == '0) ? seq_note : first_note;

    // Next-state, sequence pointer, round length and pulse decode.
    always_comb begin
        state_n    = state;
        idx_n      = seq_index;
        len_n      = round_len;
        note_n     = play_note;
        gap_last_n = gap_last;
        wrong_n    = 1'b0;
        done_n     = 1'b0;
        restart    = 1'b0;
        unique case (state)
            IDLE, FAIL, WIN: begin
                if (start) begin
                    len_n   = (IW+1)'(1);
                    idx_n   = '0;
                    note_n  = note0;
                    state_n = PLAY_NOTE;
                end
            end
            PLAY_NOTE: begin
                if (tick && tcnt == TW'(NOTE_TICKS - 1)) begin
                    // Advance during the silent gap so the next note is
                    // already on the ROM bus when its tone starts.
                    gap_last_n = last;
                    if (!last) begin
                        idx_n = seq_index + 1'b1;
                    end
                    state_n = PLAY_GAP;
                end
            end
            PLAY_GAP: begin
                if (tick && tcnt == TW'(GAP_TICKS - 1)) begin
                    if (gap_last) begin
                        idx_n   = '0;
                        state_n = LISTEN;
                    end else begin
                        note_n  = seq_note;
                        state_n = PLAY_NOTE;
                    end
                end
            end
            LISTEN: begin
                if (btn_valid) begin
`ifdef SIMON_TIMEOUT_EN
                    restart = 1'b1;
`endif
                    if (!match) begin
                        wrong_n = 1'b1;
                        state_n = FAIL;
                    end else if (!last) begin
                        idx_n = seq_index + 1'b1;
                    end else if (round_len < (IW+1)'(MAX_LEN)) begin
                        done_n  = 1'b1;
                        len_n   = round_len + 1'b1;
                        idx_n   = '0;
                        note_n  = note0;
                        state_n = PLAY_NOTE;
                    end else begin
                        done_n  = 1'b1;
                        idx_n   = '0;
                        state_n = WIN;
                    end
                end
`ifdef SIMON_TIMEOUT_EN
                else if (tick && tcnt == TW'(TIMEOUT_TICKS - 1)) begin
                    wrong_n = 1'b1;
                    state_n = FAIL;
                end
`endif
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // Tick divider and tick counter; both restart with every phase.
    always_comb begin
        div_n  = div + 1'b1;
        tcnt_n = tcnt;
        if (state_n != state || restart) begin
            div_n  = '0;
            tcnt_n = '0;
        end else if (tick) begin
            div_n  = '0;
            tcnt_n = tcnt + 1'b1;
        end
    end

    // State register and registered outputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            state            <= IDLE;
            div              <= '0;
            tcnt             <= '0;
            seq_index        <= '0;
            round_len        <= '0;
            gap_last         <= 1'b0;
            play_en          <= 1'b0;
            play_note        <= '0;
            is_music_playing <= 1'b0;
            awaiting_input   <= 1'b0;
            wrong            <= 1'b0;
            round_done       <= 1'b0;
            game_won         <= 1'b0;
        end else begin
            state            <= state_n;
            div              <= div_n;
            tcnt             <= tcnt_n;
            seq_index        <= idx_n;
            round_len        <= len_n;
            gap_last         <= gap_last_n;
            play_en          <= (state_n == PLAY_NOTE);
            play_note        <= note_n;
            is_music_playing <= (state_n == PLAY_NOTE) || (state_n == PLAY_GAP);
            awaiting_input   <= (state_n == LISTEN);
            wrong            <= wrong_n;
            round_done       <= done_n;
            game_won         <= (state_n == WIN);
        end
    end

    // Remember the first sequence note whenever the pointer sits on it.
    always_ff @(posedge clock) begin
        if (reset) begin
            first_note <= '0;
        end else if (seq_index == '0) begin
            first_note <= seq_note;
        end
    end

endmodule
